fwd_hazard_ctrl: RTL and testbench

- Pipeline control block that generates the 2-bit select codes driving the EX-stage 32-bit 3-to-1 operand muxes (regfile / EX-MEM result / MEM-WB result).
- Keeps its own shadow pipeline of destination-register info for the EX, MEM and WB slots.
- Detects load-use hazards, asserts a one-cycle stall and inserts a bubble.
- Sits beside the ID/EX pipeline register. Its registered selects change on the same edge that the operand pipeline registers load.

---
 rtl/fwd_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use stall control for the EX stage.
// Tracks destination info for the EX/MEM/WB slots alongside the ID/EX register.
module fwd_hazard_ctrl #(
    parameter int ADDR_W    = 5,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ID_Valid,
    input  logic [ADDR_W-1:0] ID_Rs,
    input  logic [ADDR_W-1:0] ID_Rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic [ADDR_W-1:0] ID_Dest,
    input  logic              Flush,
    output logic [1:0]        FwdA,
    output logic [1:0]        FwdB,
    output logic              Stall,
    output logic [CNT_W-1:0]  StallCount
);

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    // Slot valid bits are control (reset); the remaining slot fields are
    // qualified by valid, so they carry no reset.
    logic              ex_vld_q, ex_vld_d;
    logic              mem_vld_q, mem_vld_d;
    logic              wb_vld_q, wb_vld_d;
    logic              ex_rw_q, ex_rw_d;
    logic              ex_mr_q, ex_mr_d;
    logic [ADDR_W-1:0] ex_dest_q, ex_dest_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_dest_q, mem_dest_d;
    logic              wb_rw_q, wb_rw_d;
    logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [1:0]        fwda_q, fwda_d;
    logic [1:0]        fwdb_q, fwdb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              stall;
    logic              bubble;

    function automatic logic slot_hit(
        input logic              uses,
        input logic [ADDR_W-1:0] src,
        input logic              vld,
        input logic              rw,
        input logic [ADDR_W-1:0] dest
    );
        return uses && (src != ZERO_REG) && vld && rw && (src == dest);
    endfunction

    // Nearest producer wins; a WB producer is already visible through the
    // write-first regfile, so it selects the regfile path.
    function automatic logic [1:0] fwd_sel(
        input logic ex_hit,
        input logic mem_hit,
        input logic wb_hit
    );
        if (ex_hit)       return 2'd1;
        else if (mem_hit) return 2'd2;
        else if (wb_hit)  return 2'd0;
        else              return 2'd0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    always_comb begin
        stall = HAZARD_EN && ID_Valid && ex_vld_q && ex_mr_q && (ex_dest_q != ZERO_REG)
                && ((ID_UsesRs && (ID_Rs == ex_dest_q)) || (ID_UsesRt && (ID_Rt == ex_dest_q)));
        bubble = stall || Flush || !ID_Valid;
    end

    always_comb begin
        ex_vld_d   = !bubble;
        ex_rw_d    = ID_RegWrite;
        ex_mr_d    = ID_MemRead;
        ex_dest_d  = ID_Dest;
        mem_vld_d  = ex_vld_q;
        mem_rw_d   = ex_rw_q;
        mem_dest_d = ex_dest_q;
        wb_vld_d   = mem_vld_q;
        wb_rw_d    = mem_rw_q;
        wb_dest_d  = mem_dest_q;
        fwda_d     = 2'd0;
        fwdb_d     = 2'd0;
        if (!bubble) begin
            fwda_d = fwd_sel(slot_hit(ID_UsesRs, ID_Rs, ex_vld_q, ex_rw_q, ex_dest_q),
                             slot_hit(ID_UsesRs, ID_Rs, mem_vld_q, mem_rw_q, mem_dest_q),
                             slot_hit(ID_UsesRs, ID_Rs, wb_vld_q, wb_rw_q, wb_dest_q));
            fwdb_d = fwd_sel(slot_hit(ID_UsesRt, ID_Rt, ex_vld_q, ex_rw_q, ex_dest_q),
                             slot_hit(ID_UsesRt, ID_Rt, mem_vld_q, mem_rw_q, mem_dest_q),
                             slot_hit(ID_UsesRt, ID_Rt, wb_vld_q, wb_rw_q, wb_dest_q));
        end
        cnt_d = stall ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_vld_q  <= 1'b0;
            mem_vld_q <= 1'b0;
            wb_vld_q  <= 1'b0;
            fwda_q    <= 2'd0;
            fwdb_q    <= 2'd0;
            cnt_q     <= '0;
        end else begin
            ex_vld_q  <= ex_vld_d;
            mem_vld_q <= mem_vld_d;
            wb_vld_q  <= wb_vld_d;
            fwda_q    <= fwda_d;
            fwdb_q    <= fwdb_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge Clk) begin
        ex_rw_q    <= ex_rw_d;
        ex_mr_q    <= ex_mr_d;
        ex_dest_q  <= ex_dest_d;
        mem_rw_q   <= mem_rw_d;
        mem_dest_q <= mem_dest_d;
        wb_rw_q    <= wb_rw_d;
        wb_dest_q  <= wb_dest_d;
    end

    assign FwdA       = fwda_q;
    assign FwdB       = fwdb_q;
    assign Stall      = stall;
    assign StallCount = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: one table row per instruction in ID,
// plus hand sequences for asynchronous reset behaviour.
module tb_fwd_hazard_ctrl;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 32;
    localparam int NVEC   = 26;

    logic              Clk;
    logic              Rst_n;
    logic              ID_Valid;
    logic [ADDR_W-1:0] ID_Rs;
    logic [ADDR_W-1:0] ID_Rt;
    logic              ID_UsesRs;
    logic              ID_UsesRt;
    logic              ID_RegWrite;
    logic              ID_MemRead;
    logic [ADDR_W-1:0] ID_Dest;
    logic              Flush;
    logic [1:0]        FwdA;
    logic [1:0]        FwdB;
    logic              Stall;
    logic [CNT_W-1:0]  StallCount;

    fwd_hazard_ctrl #(.ADDR_W(ADDR_W), .HAZARD_EN(1'b1), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .ID_Dest(ID_Dest), .Flush(Flush),
        .FwdA(FwdA), .FwdB(FwdB), .Stall(Stall), .StallCount(StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Row: instruction presented in ID this cycle; st is the expected Stall
    // during the cycle, fa/fb/cnt the expected outputs after the edge.
    typedef struct {
        int v, rs, rt, urs, urt, rw, mr, dest, fl;
        int st, fa, fb, cnt;
    } vec_t;

    vec_t tbl [NVEC];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int v, input int rs, input int rt, input int urs, input int urt,
                         input int rw, input int mr, input int dest, input int fl);
        ID_Valid    = v[0];
        ID_Rs       = rs[ADDR_W-1:0];
        ID_Rt       = rt[ADDR_W-1:0];
        ID_UsesRs   = urs[0];
        ID_UsesRt   = urt[0];
        ID_RegWrite = rw[0];
        ID_MemRead  = mr[0];
        ID_Dest     = dest[ADDR_W-1:0];
        Flush       = fl[0];
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //            v  rs rt urs urt rw mr dest fl   st fa fb cnt
        tbl[0]  = '{1, 1, 2, 1, 1, 1, 0, 3,  0,  0, 0, 0, 0}; // add $3
        tbl[1]  = '{1, 3, 4, 1, 1, 1, 0, 6,  0,  0, 1, 0, 0}; // sub uses $3 -> EX/MEM
        tbl[2]  = '{1, 7, 7, 1, 1, 1, 0, 5,  0,  0, 0, 0, 0}; // producer $5
        tbl[3]  = '{1, 1, 1, 1, 1, 1, 0, 9,  0,  0, 0, 0, 0}; // filler $9
        tbl[4]  = '{1, 6, 5, 1, 1, 0, 0, 0,  0,  0, 0, 2, 0}; // $5 dist 2, $6 in WB
        tbl[5]  = '{1, 1, 1, 0, 0, 1, 0, 5,  0,  0, 0, 0, 0}; // $5 again
        tbl[6]  = '{1, 1, 1, 0, 0, 1, 0, 5,  0,  0, 0, 0, 0}; // $5 again
        tbl[7]  = '{1, 5, 5, 1, 1, 0, 0, 0,  0,  0, 1, 1, 0}; // EX and MEM hit -> 1
        tbl[8]  = '{1, 2, 1, 1, 0, 1, 1, 8,  0,  0, 0, 0, 0}; // lw $8
        tbl[9]  = '{1, 8, 1, 1, 1, 1, 0, 10, 0,  1, 0, 0, 1}; // load-use stall
        tbl[10] = '{1, 8, 1, 1, 1, 1, 0, 10, 0,  0, 2, 0, 1}; // re-presented -> MEM/WB
        tbl[11] = '{1, 0, 0, 1, 1, 1, 1, 0,  0,  0, 0, 0, 1}; // lw $0
        tbl[12] = '{1, 0, 0, 1, 1, 0, 0, 0,  0,  0, 0, 0, 1}; // uses $0, no stall
        tbl[13] = '{1, 1, 1, 0, 0, 0, 0, 12, 0,  0, 0, 0, 1}; // non-writer dest 12
        tbl[14] = '{1, 12, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1}; // no fwd from non-writer
        tbl[15] = '{1, 1, 1, 0, 0, 1, 0, 13, 1,  0, 0, 0, 1}; // flushed producer $13
        tbl[16] = '{1, 13, 13, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1}; // no fwd from flushed
        tbl[17] = '{1, 1, 1, 0, 0, 1, 0, 14, 0,  0, 0, 0, 1}; // producer $14
        tbl[18] = '{0, 14, 14, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1}; // invalid slot -> bubble
        tbl[19] = '{1, 14, 1, 1, 0, 0, 0, 0,  0,  0, 2, 0, 1}; // $14 now in MEM
        tbl[20] = '{1, 1, 1, 1, 0, 1, 1, 15, 0,  0, 0, 0, 1}; // lw $15
        tbl[21] = '{1, 0, 15, 0, 1, 1, 0, 16, 0, 1, 0, 0, 2}; // load-use via Rt
        tbl[22] = '{1, 0, 15, 0, 1, 1, 0, 16, 0, 0, 0, 2, 2}; // resolves FwdB=2
        tbl[23] = '{1, 1, 1, 0, 0, 1, 1, 21, 0,  0, 0, 0, 2}; // lw $21
        tbl[24] = '{1, 21, 1, 1, 0, 1, 0, 22, 1, 1, 0, 0, 3}; // stall not gated by Flush
        tbl[25] = '{1, 21, 1, 1, 0, 1, 0, 22, 0, 0, 2, 0, 3}; // then MEM hit

        // Reset asserted with arbitrary inputs: outputs clear before any edge.
        Rst_n = 1'b0;
        drive(1, $urandom_range(31), $urandom_range(31), 1, 1, 1, 1, $urandom_range(31), 0);
        #1;
        chk("reset FwdA", FwdA, 0);
        chk("reset FwdB", FwdB, 0);
        chk("reset Stall", Stall, 0);
        chk("reset StallCount", StallCount, 0);
        @(posedge Clk);
        #1;
        chk("reset held FwdA", FwdA, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
                  tbl[i].rw, tbl[i].mr, tbl[i].dest, tbl[i].fl);
            #1;
            chk($sformatf("vec%0d Stall", i), Stall, tbl[i].st);
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d FwdA", i), FwdA, tbl[i].fa);
            chk($sformatf("vec%0d FwdB", i), FwdB, tbl[i].fb);
            chk($sformatf("vec%0d StallCount", i), StallCount, tbl[i].cnt);
        end

        // Mid-stream reset: a pending load-use is dropped and nothing forwards
        // from the pre-reset load afterwards.
        drive(1, 1, 1, 0, 0, 1, 1, 20, 0);                // lw $20
        @(posedge Clk);
        #1;
        drive(1, 20, 1, 1, 0, 1, 0, 23, 0);               // consumer of $20
        #1;
        chk("pre-reset Stall", Stall, 1);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("mid-reset Stall", Stall, 0);
        chk("mid-reset StallCount", StallCount, 0);
        chk("mid-reset FwdA", FwdA, 0);
        #2;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("post-reset FwdA", FwdA, 0);
        chk("post-reset FwdB", FwdB, 0);
        chk("post-reset StallCount", StallCount, 0);
        drive(1, 20, 20, 1, 1, 0, 0, 0, 0);               // $20 again, only consumer ahead
        #1;
        chk("post-reset Stall", Stall, 0);
        @(posedge Clk);
        #1;
        chk("post-reset2 FwdA", FwdA, 0);
        chk("post-reset2 FwdB", FwdB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
